// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: op select, signedness flags,
// FSM states and small sign helpers.
package muldiv_unit_pkg;

  localparam logic MD_OP_MUL   = 1'b0;
  localparam logic MD_OP_DIV   = 1'b1;
  localparam logic MD_SIGNED   = 1'b0;
  localparam logic MD_UNSIGNED = 1'b1;

  localparam int unsigned DIV_CYCLES = 33;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] ALL_ONES   = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef logic [63:0] dreg_t;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring radix-2 divider core on unsigned magnitudes: one quotient bit per step,
// 32 steps after load; clr_i abandons the operation.
module muldiv_div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        clr_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        last_o,
  output logic        busy_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q, dsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        qbit;

  // Dividend bits leave the top of the quotient register as quotient bits enter the bottom.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dsr_q};
  assign qbit    = ~diff[32];

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load_i) begin
      rem_d  = 32'd0;
      quo_d  = dividend_i;
      dsr_d  = divisor_i;
      cnt_d  = 5'd0;
      busy_d = 1'b1;
    end else if (clr_i) begin
      cnt_d  = 5'd0;
      busy_d = 1'b0;
    end else if (step_i && busy_q) begin
      rem_d = qbit ? diff[31:0] : shifted[31:0];
      quo_d = {quo_q[30:0], qbit};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dsr_q  <= 32'd0;
      cnt_q  <= 5'd0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = busy_q && (cnt_q == 5'd31);
  assign busy_o      = busy_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide responder: MUL done MUL_CYCLES edges after acceptance, DIV after 33,
// DIV special cases after the acceptance edge; dropping start before done aborts silently.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        muldiv_start_i,
  input  logic        mul_or_div_i,
  input  logic [31:0] muldiv_dividend_i,
  input  logic [31:0] muldiv_divisor_i,
  input  logic        muldiv_reg1_signed0_unsigned1_i,
  input  logic        muldiv_reg2_signed0_unsigned1_i,
  output logic [63:0] muldiv_result_o,
  output logic        muldiv_done_o,
  output logic        muldiv_busy_o
);

  md_state_e   state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        a_uns_q, a_uns_d;
  logic        b_uns_q, b_uns_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        mul_stage_q, mul_stage_d;
  dreg_t       prod_q, prod_d;
  dreg_t       result_q, result_d;

  logic        div_load, div_step, div_clr, div_last, div_busy;
  logic [31:0] div_quo, div_rem;
  logic        div_signed, div_zero, div_ovf;
  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_a_ext, mul_b_ext, mul_prod;

  // Extending the 33-bit operands straight to 64 bits gives the same low 64 product bits.
  assign mul_a_ext = {{32{~a_uns_q & op_a_q[31]}}, op_a_q};
  assign mul_b_ext = {{32{~b_uns_q & op_b_q[31]}}, op_b_q};
  assign mul_prod  = mul_a_ext * mul_b_ext;

  assign div_signed = (muldiv_reg1_signed0_unsigned1_i == MD_SIGNED);
  assign div_zero   = (muldiv_divisor_i == ZERO_WORD);
  assign div_ovf    = div_signed && (muldiv_dividend_i == INT_MIN) && (muldiv_divisor_i == ALL_ONES);
  assign abs_a      = neg_if(muldiv_dividend_i, div_signed & muldiv_dividend_i[31]);
  assign abs_b      = neg_if(muldiv_divisor_i, div_signed & muldiv_divisor_i[31]);

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    a_uns_d     = a_uns_q;
    b_uns_d     = b_uns_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    mul_stage_d = mul_stage_q;
    prod_d      = prod_q;
    result_d    = result_q;
    div_load    = 1'b0;
    div_step    = 1'b0;
    div_clr     = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (muldiv_start_i) begin
          op_a_d  = muldiv_dividend_i;
          op_b_d  = muldiv_divisor_i;
          a_uns_d = muldiv_reg1_signed0_unsigned1_i;
          b_uns_d = muldiv_reg2_signed0_unsigned1_i;
          if (mul_or_div_i == MD_OP_MUL) begin
            mul_stage_d = 1'b0;
            state_d     = MD_MUL;
          end else if (div_zero) begin
            result_d = {ALL_ONES, muldiv_dividend_i};
            state_d  = MD_DONE;
          end else if (div_ovf) begin
            result_d = {INT_MIN, ZERO_WORD};
            state_d  = MD_DONE;
          end else begin
            div_load  = 1'b1;
            quo_neg_d = div_signed & (muldiv_dividend_i[31] ^ muldiv_divisor_i[31]);
            rem_neg_d = div_signed & muldiv_dividend_i[31];
            state_d   = MD_DIV;
          end
        end
      end
      MD_MUL: begin
        if (!muldiv_start_i) begin
          state_d = MD_IDLE;
        end else if (MUL_CYCLES == 1) begin
          result_d = mul_prod;
          state_d  = MD_DONE;
        end else if (mul_stage_q) begin
          result_d = prod_q;
          state_d  = MD_DONE;
        end else begin
          prod_d      = mul_prod;
          mul_stage_d = 1'b1;
        end
      end
      MD_DIV: begin
        if (!muldiv_start_i) begin
          div_clr = 1'b1;
          state_d = MD_IDLE;
        end else begin
          div_step = div_busy;
          if (div_last) begin
            state_d = MD_FIX;
          end
        end
      end
      MD_FIX: begin
        if (!muldiv_start_i) begin
          state_d = MD_IDLE;
        end else begin
          result_d = {neg_if(div_quo, quo_neg_q), neg_if(div_rem, rem_neg_q)};
          state_d  = MD_DONE;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MD_IDLE;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      a_uns_q     <= 1'b0;
      b_uns_q     <= 1'b0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      mul_stage_q <= 1'b0;
      prod_q      <= 64'd0;
      result_q    <= 64'd0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      a_uns_q     <= a_uns_d;
      b_uns_q     <= b_uns_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      mul_stage_q <= mul_stage_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
    end
  end

  muldiv_div_iter u_div_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (div_load),
    .step_i      (div_step),
    .clr_i       (div_clr),
    .dividend_i  (abs_a),
    .divisor_i   (abs_b),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .last_o      (div_last),
    .busy_o      (div_busy)
  );

  assign muldiv_result_o = result_q;
  assign muldiv_done_o   = (state_q == MD_DONE);
  assign muldiv_busy_o   = (state_q != MD_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; latency counted in edges after the acceptance edge.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mul_or_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        f1;
  logic        f2;
  logic [63:0] result;
  logic        done;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.MUL_CYCLES(2)) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .muldiv_start_i                  (start),
    .mul_or_div_i                    (mul_or_div),
    .muldiv_dividend_i               (dividend),
    .muldiv_divisor_i                (divisor),
    .muldiv_reg1_signed0_unsigned1_i (f1),
    .muldiv_reg2_signed0_unsigned1_i (f2),
    .muldiv_result_o                 (result),
    .muldiv_done_o                   (done),
    .muldiv_busy_o                   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise start, scramble operands after acceptance, wait for done, then release start.
  task automatic run_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic fa, input logic fb, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    lat = -1;
    @(negedge clk);
    mul_or_div = op;
    dividend   = a;
    divisor    = b;
    f1         = fa;
    f2         = fb;
    start      = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        dividend = ~a;
        divisor  = 32'd0;
        f1       = ~fa;
        f2       = ~fb;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    check_vec({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_vec({tag, "_result"}, result, exp_res);
    check_vec({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_vec({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check_vec({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic seen_done;
    rst_n      = 1'b0;
    start      = 1'b0;
    mul_or_div = MD_OP_MUL;
    dividend   = 32'd0;
    divisor    = 32'd0;
    f1         = MD_SIGNED;
    f2         = MD_SIGNED;
    #12;
    check_vec("reset_result", result, 64'd0);
    check_vec("reset_done", 64'(done), 64'd0);
    check_vec("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mulhu_max", MD_OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, MD_UNSIGNED, MD_UNSIGNED,
           64'hFFFFFFFE_00000001, 2);
    run_op("mulh_m2x3", MD_OP_MUL, 32'hFFFFFFFE, 32'd3, MD_SIGNED, MD_SIGNED,
           64'hFFFFFFFF_FFFFFFFA, 2);
    run_op("mulhsu", MD_OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, MD_SIGNED, MD_UNSIGNED,
           64'hFFFFFFFF_00000001, 2);
    run_op("div_m7_2", MD_OP_DIV, 32'hFFFFFFF9, 32'd2, MD_SIGNED, MD_SIGNED,
           {32'hFFFFFFFD, 32'hFFFFFFFF}, DIV_CYCLES);
    run_op("div_7_m2", MD_OP_DIV, 32'd7, 32'hFFFFFFFE, MD_SIGNED, MD_SIGNED,
           {32'hFFFFFFFD, 32'h00000001}, DIV_CYCLES);
    run_op("divu_100_7", MD_OP_DIV, 32'd100, 32'd7, MD_UNSIGNED, MD_UNSIGNED,
           {32'h0000000E, 32'h00000002}, DIV_CYCLES);
    // Special cases complete on the acceptance edge itself.
    run_op("divu_by0", MD_OP_DIV, 32'd100, 32'd0, MD_UNSIGNED, MD_UNSIGNED,
           {32'hFFFFFFFF, 32'h00000064}, 0);
    run_op("div_by0_neg", MD_OP_DIV, 32'hFFFFFFFB, 32'd0, MD_SIGNED, MD_SIGNED,
           {32'hFFFFFFFF, 32'hFFFFFFFB}, 0);
    run_op("div_ovf", MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, MD_SIGNED, MD_SIGNED,
           {32'h80000000, 32'h00000000}, 0);

    // Abort a DIV ten cycles in; previous result must survive.
    seen_done = 1'b0;
    @(negedge clk);
    mul_or_div = MD_OP_DIV;
    dividend   = 32'd1000;
    divisor    = 32'd3;
    f1         = MD_UNSIGNED;
    f2         = MD_UNSIGNED;
    start      = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | done;
    end
    check_vec("abort_busy_mid", 64'(busy), 64'd1);
    start = 1'b0;
    @(posedge clk);
    #1;
    seen_done = seen_done | done;
    check_vec("abort_no_done", 64'(seen_done), 64'd0);
    check_vec("abort_busy_after", 64'(busy), 64'd0);
    check_vec("abort_result_kept", result, {32'h80000000, 32'h00000000});
    run_op("mul_6x7", MD_OP_MUL, 32'd6, 32'd7, MD_SIGNED, MD_SIGNED, 64'h0000_0000_0000_002A, 2);

    // Async reset in the middle of a DIV clears outputs without a clock edge.
    seen_done = 1'b0;
    @(negedge clk);
    mul_or_div = MD_OP_DIV;
    dividend   = 32'd1000;
    divisor    = 32'd3;
    start      = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("arst_result", result, 64'd0);
    check_vec("arst_busy", 64'(busy), 64'd0);
    check_vec("arst_done", 64'(done), 64'd0);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    check_vec("arst_no_done", 64'(seen_done), 64'd0);
    rst_n = 1'b1;

    run_op("b2b_divu", MD_OP_DIV, 32'hFFFFFFFF, 32'd16, MD_UNSIGNED, MD_UNSIGNED,
           {32'h0FFFFFFF, 32'h0000000F}, DIV_CYCLES);
    run_op("b2b_mul", MD_OP_MUL, 32'h80000000, 32'h80000000, MD_SIGNED, MD_SIGNED,
           64'h40000000_00000000, 2);
    run_op("divu_small", MD_OP_DIV, 32'd5, 32'd9, MD_UNSIGNED, MD_UNSIGNED,
           {32'h00000000, 32'h00000005}, DIV_CYCLES);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
